// File: rtl/clint_timer.sv
//------------------------------------------------------------------------------
// clint_timer
//
// Core-local interruptor for the small core. Holds the 64-bit mtime counter,
// the 64-bit mtimecmp compare register and the msip software-interrupt bit,
// drives the machine timer / software interrupt lines to the CSR unit and
// exposes all three registers as 32-bit words on the system memory bus.
//
// mtime advances once per RTC tick. The tick is derived from the core clock:
// a divider counts 0 .. 2*(rtc_div+1)-1 and the tick is the cycle in which it
// sits at its maximum (every 10 core clocks at the default setting).
//
// Register map (byte offset from clint_base_addr, 32-bit words):
//   0x0000  msip          (bit 0 only)
//   0x4000  mtimecmp[31:0]
//   0x4004  mtimecmp[63:32]
//   0xBFF8  mtime[31:0]
//   0xBFFC  mtime[63:32]
//   other   read as zero, writes ignored, still acknowledged
//
// Ports:
//   clock        core clock, all state updates on its rising edge
//   reset        synchronous, active-high reset
//   clint_valid  bus request strobe (window already selected upstream)
//   clint_addr   absolute byte address
//   clint_wdata  write data
//   clint_wstrb  byte write enables, all zero means a read
//   clint_rdata  read data, valid while clint_ready is high, zero otherwise
//   clint_ready  one-cycle response pulse, one cycle after clint_valid
//   clint_msip   machine software interrupt pending
//   clint_mtip   machine timer interrupt pending (mtime >= mtimecmp)
//   clint_mtime  current mtime, for the time/timeh CSRs
//------------------------------------------------------------------------------

package configure;
    // RTC half-period in core clocks, minus 1.
    localparam int unsigned clk_divider_rtc = 4;
    // Bus window occupied by the CLINT.
    localparam logic [31:0] clint_base_addr = 32'h0200_0000;
    localparam logic [31:0] clint_top_addr  = 32'h0200_FFFF;
endpackage

module clint_timer #(
    parameter int unsigned rtc_div = configure::clk_divider_rtc
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        clint_valid,
    input  logic [31:0] clint_addr,
    input  logic [31:0] clint_wdata,
    input  logic [3:0]  clint_wstrb,
    output logic [31:0] clint_rdata,
    output logic        clint_ready,
    output logic        clint_msip,
    output logic        clint_mtip,
    output logic [63:0] clint_mtime
);

    //--------------------------------------------------------------------------
    // Constants
    //--------------------------------------------------------------------------
    localparam int unsigned     DIV_MAX  = 2 * (rtc_div + 1) - 1;
    localparam int unsigned     DIV_W    = $clog2(DIV_MAX + 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV_MAX);

    // Word indices (byte offset >> 2) of the implemented registers.
    localparam logic [13:0] WORD_MSIP     = 14'h0000;  // 0x0000
    localparam logic [13:0] WORD_CMP_LO   = 14'h1000;  // 0x4000
    localparam logic [13:0] WORD_CMP_HI   = 14'h1001;  // 0x4004
    localparam logic [13:0] WORD_TIME_LO  = 14'h2FFE;  // 0xBFF8
    localparam logic [13:0] WORD_TIME_HI  = 14'h2FFF;  // 0xBFFC

    localparam logic [63:0] MTIMECMP_RST  = 64'hFFFF_FFFF_FFFF_FFFF;

    typedef enum logic [2:0] {
        SEL_NONE,
        SEL_MSIP,
        SEL_CMP_LO,
        SEL_CMP_HI,
        SEL_TIME_LO,
        SEL_TIME_HI
    } reg_sel_e;

    //--------------------------------------------------------------------------
    // Byte-lane merge: each set strobe bit takes the new byte, the rest keep
    // the base value.
    //--------------------------------------------------------------------------
    function automatic logic [31:0] merge_bytes(
        input logic [31:0] base_val,
        input logic [31:0] new_val,
        input logic [3:0]  strb
    );
        logic [31:0] result;
        for (int i = 0; i < 4; i++) begin
            result[i*8 +: 8] = strb[i] ? new_val[i*8 +: 8] : base_val[i*8 +: 8];
        end
        return result;
    endfunction

    //--------------------------------------------------------------------------
    // State
    //--------------------------------------------------------------------------
    logic [DIV_W-1:0] div_cnt_q,  div_cnt_d;
    logic [63:0]      mtime_q,    mtime_d;
    logic [63:0]      mtimecmp_q, mtimecmp_d;
    logic             msip_q,     msip_d;
    logic             mtip_q,     mtip_d;
    logic             ready_q,    ready_d;
    logic [31:0]      rdata_q,    rdata_d;

    //--------------------------------------------------------------------------
    // Address decode
    //--------------------------------------------------------------------------
    logic [31:0] offset;
    logic [13:0] word_idx;
    reg_sel_e    sel;
    logic        is_write;
    logic        wr_en;
    logic        unused_offset_bits;

    // Only offset bits [15:2] select a word; the window decoder upstream has
    // already qualified the upper bits.
    assign offset             = clint_addr - configure::clint_base_addr;
    assign word_idx           = offset[15:2];
    assign unused_offset_bits = ^{offset[31:16], offset[1:0]};

    assign is_write = |clint_wstrb;
    assign wr_en    = clint_valid && is_write;

    always_comb begin
        case (word_idx)
            WORD_MSIP:    sel = SEL_MSIP;
            WORD_CMP_LO:  sel = SEL_CMP_LO;
            WORD_CMP_HI:  sel = SEL_CMP_HI;
            WORD_TIME_LO: sel = SEL_TIME_LO;
            WORD_TIME_HI: sel = SEL_TIME_HI;
            default:      sel = SEL_NONE;
        endcase
    end

    //--------------------------------------------------------------------------
    // Read mux: returns register contents as they stand at the sampling edge,
    // i.e. before any tick or write that lands on that same edge.
    //--------------------------------------------------------------------------
    logic [31:0] read_word;

    always_comb begin
        case (sel)
            SEL_MSIP:    read_word = {31'd0, msip_q};
            SEL_CMP_LO:  read_word = mtimecmp_q[31:0];
            SEL_CMP_HI:  read_word = mtimecmp_q[63:32];
            SEL_TIME_LO: read_word = mtime_q[31:0];
            SEL_TIME_HI: read_word = mtime_q[63:32];
            default:     read_word = 32'd0;
        endcase
    end

    //--------------------------------------------------------------------------
    // RTC tick and mtime increment
    //--------------------------------------------------------------------------
    logic        tick;
    logic [63:0] mtime_inc;

    assign tick = (div_cnt_q == DIV_LAST);

    // Full 64-bit add so the carry crosses the two bus halves in one cycle;
    // wraps naturally from all ones to zero.
    assign mtime_inc = mtime_q + {63'd0, tick};

    //--------------------------------------------------------------------------
    // Next-state logic
    //--------------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal driven here gets a default before any branch so
        // no path leaves it unassigned, which would otherwise infer a latch.
        div_cnt_d  = tick ? '0 : div_cnt_q + DIV_W'(1);
        mtime_d    = mtime_inc;
        mtimecmp_d = mtimecmp_q;
        msip_d     = msip_q;

        // A write to an mtime half overrides the written bytes only; the
        // other bytes of the 64-bit value still advance with the tick, using
        // the carry computed from the old value.
        if (wr_en) begin
            case (sel)
                SEL_MSIP: begin
                    if (clint_wstrb[0]) begin
                        msip_d = clint_wdata[0];
                    end
                end
                SEL_CMP_LO:  mtimecmp_d[31:0]  = merge_bytes(mtimecmp_q[31:0],  clint_wdata, clint_wstrb);
                SEL_CMP_HI:  mtimecmp_d[63:32] = merge_bytes(mtimecmp_q[63:32], clint_wdata, clint_wstrb);
                SEL_TIME_LO: mtime_d[31:0]     = merge_bytes(mtime_inc[31:0],   clint_wdata, clint_wstrb);
                SEL_TIME_HI: mtime_d[63:32]    = merge_bytes(mtime_inc[63:32],  clint_wdata, clint_wstrb);
                default: ;
            endcase
        end

        // Compare the values being loaded, so mtip changes on the same edge
        // as the registers it depends on.
        mtip_d = (mtime_d >= mtimecmp_d);

        // Every accepted request gets exactly one response next cycle; write
        // responses carry no data.
        ready_d = clint_valid;
        rdata_d = (clint_valid && !is_write) ? read_word : 32'd0;
    end

    //--------------------------------------------------------------------------
    // Registers
    //--------------------------------------------------------------------------
    always_ff @(posedge clock) begin
        // NOTE: state is updated with non-blocking assignments so every flop
        // samples the pre-edge values regardless of statement order.
        if (reset) begin
            div_cnt_q  <= '0;
            mtime_q    <= 64'd0;
            mtimecmp_q <= MTIMECMP_RST;
            msip_q     <= 1'b0;
            mtip_q     <= 1'b0;
            ready_q    <= 1'b0;
            rdata_q    <= 32'd0;
        end else begin
            div_cnt_q  <= div_cnt_d;
            mtime_q    <= mtime_d;
            mtimecmp_q <= mtimecmp_d;
            msip_q     <= msip_d;
            mtip_q     <= mtip_d;
            ready_q    <= ready_d;
            rdata_q    <= rdata_d;
        end
    end

    //--------------------------------------------------------------------------
    // Outputs
    //--------------------------------------------------------------------------
    assign clint_rdata = rdata_q;
    assign clint_ready = ready_q;
    assign clint_msip  = msip_q;
    assign clint_mtip  = mtip_q;
    assign clint_mtime = mtime_q;

endmodule

// File: tb/tb_clint_timer.sv
//------------------------------------------------------------------------------
// tb_clint_timer
//
// Randomized and directed stimulus for clint_timer. A behavioural model of the
// CLINT (64-bit counters, byte-merged writes, tick every 10 core clocks)
// runs alongside the DUT. Each accepted request pushes its expected response
// into a scoreboard queue; an independent monitor on the falling edge pops and
// compares whenever a response is due, and compares mtime/mtip/msip every
// cycle.
//------------------------------------------------------------------------------
module tb_clint_timer;

    localparam int          TICK_PERIOD = 10;
    localparam logic [31:0] BASE        = configure::clint_base_addr;

    localparam logic [31:0] OFF_MSIP    = 32'h0000;
    localparam logic [31:0] OFF_CMP_LO  = 32'h4000;
    localparam logic [31:0] OFF_CMP_HI  = 32'h4004;
    localparam logic [31:0] OFF_TIME_LO = 32'hBFF8;
    localparam logic [31:0] OFF_TIME_HI = 32'hBFFC;

    typedef struct {
        logic [31:0] rdata;
        bit          is_read;
    } resp_t;

    // DUT signals
    logic        clock       = 1'b0;
    logic        reset       = 1'b1;
    logic        clint_valid = 1'b0;
    logic [31:0] clint_addr  = 32'd0;
    logic [31:0] clint_wdata = 32'd0;
    logic [3:0]  clint_wstrb = 4'd0;
    logic [31:0] clint_rdata;
    logic        clint_ready;
    logic        clint_msip;
    logic        clint_mtip;
    logic [63:0] clint_mtime;

    // Counters
    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    logic [63:0] m_mtime;
    logic [63:0] m_cmp;
    logic        m_msip;
    logic        m_mtip;
    int          m_cnt;        // core clocks since reset
    bit          m_live = 1'b0;
    resp_t       sb_q[$];

    always #5 clock = ~clock;

    clint_timer dut (
        .clock       (clock),
        .reset       (reset),
        .clint_valid (clint_valid),
        .clint_addr  (clint_addr),
        .clint_wdata (clint_wdata),
        .clint_wstrb (clint_wstrb),
        .clint_rdata (clint_rdata),
        .clint_ready (clint_ready),
        .clint_msip  (clint_msip),
        .clint_mtip  (clint_mtip),
        .clint_mtime (clint_mtime)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    //--------------------------------------------------------------------------
    // Reference model: evaluated on every rising edge from the inputs the
    // driver set up on the previous falling edge.
    //--------------------------------------------------------------------------
    initial begin : model
        logic [31:0] off;
        logic [31:0] rd;
        logic [63:0] nt;
        logic [63:0] nc;
        logic        nm;
        logic        tick;
        bit          wr;
        forever begin
            @(posedge clock);
            if (reset) begin
                m_mtime = 64'd0;
                m_cmp   = 64'hFFFF_FFFF_FFFF_FFFF;
                m_msip  = 1'b0;
                m_mtip  = 1'b0;
                m_cnt   = 0;
                sb_q.delete();
                m_live  = 1'b1;
            end else if (m_live) begin
                // mtime advances on the 10th, 20th, ... clock after reset.
                tick  = ((m_cnt % TICK_PERIOD) == TICK_PERIOD - 1);
                m_cnt = m_cnt + 1;
                nt = m_mtime + (tick ? 64'd1 : 64'd0);
                nc = m_cmp;
                nm = m_msip;
                if (clint_valid) begin
                    off = clint_addr - BASE;
                    off = off & 32'h0000_FFFC;
                    case (off)
                        OFF_MSIP:    rd = {31'd0, m_msip};
                        OFF_CMP_LO:  rd = m_cmp[31:0];
                        OFF_CMP_HI:  rd = m_cmp[63:32];
                        OFF_TIME_LO: rd = m_mtime[31:0];
                        OFF_TIME_HI: rd = m_mtime[63:32];
                        default:     rd = 32'd0;
                    endcase
                    wr = (clint_wstrb != 4'd0);
                    sb_q.push_back('{rdata: (wr ? 32'd0 : rd), is_read: !wr});
                    if (wr) begin
                        for (int b = 0; b < 4; b++) begin
                            if (clint_wstrb[b]) begin
                                case (off)
                                    OFF_MSIP:    if (b == 0) nm = clint_wdata[0];
                                    OFF_CMP_LO:  nc[b*8 +: 8]      = clint_wdata[b*8 +: 8];
                                    OFF_CMP_HI:  nc[32 + b*8 +: 8] = clint_wdata[b*8 +: 8];
                                    OFF_TIME_LO: nt[b*8 +: 8]      = clint_wdata[b*8 +: 8];
                                    OFF_TIME_HI: nt[32 + b*8 +: 8] = clint_wdata[b*8 +: 8];
                                    default: ;
                                endcase
                            end
                        end
                    end
                end
                m_mtime = nt;
                m_cmp   = nc;
                m_msip  = nm;
                m_mtip  = (nt >= nc);
            end
        end
    end

    //--------------------------------------------------------------------------
    // Monitor: falling-edge comparison of outputs against the model.
    //--------------------------------------------------------------------------
    initial begin : monitor
        resp_t e;
        forever begin
            @(negedge clock);
            if (m_live) begin
                if (sb_q.size() > 0) begin
                    e = sb_q.pop_front();
                    check("resp_ready", {63'd0, clint_ready}, 64'd1);
                    if (e.is_read) begin
                        check("resp_rdata", {32'd0, clint_rdata}, {32'd0, e.rdata});
                    end
                end else begin
                    check("idle_ready", {63'd0, clint_ready}, 64'd0);
                    check("idle_rdata", {32'd0, clint_rdata}, 64'd0);
                end
                check("mtime", clint_mtime, m_mtime);
                check("mtip", {63'd0, clint_mtip}, {63'd0, m_mtip});
                check("msip", {63'd0, clint_msip}, {63'd0, m_msip});
            end
        end
    end

    //--------------------------------------------------------------------------
    // Driver helpers (always entered and left on a falling edge)
    //--------------------------------------------------------------------------
    task automatic bus_req(input logic [31:0] off, input logic [31:0] data, input logic [3:0] strb);
        clint_valid = 1'b1;
        clint_addr  = BASE + off;
        clint_wdata = data;
        clint_wstrb = strb;
        @(negedge clock);
        clint_valid = 1'b0;
        clint_wstrb = 4'd0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clock);
    endtask

    // Wait until the next rising edge is at position k of the tick period
    // (k = 9 means that edge carries a tick).
    task automatic align_phase(input int k);
        int guard;
        guard = 0;
        while ((m_cnt % TICK_PERIOD) != k && guard < 2 * TICK_PERIOD) begin
            @(negedge clock);
            guard++;
        end
        if ((m_cnt % TICK_PERIOD) != k) begin
            check("align_phase", 64'(m_cnt % TICK_PERIOD), 64'(k));
        end
    endtask

    task automatic wait_mtime_change(output int cycles);
        logic [63:0] old;
        old    = clint_mtime;
        cycles = 0;
        while (clint_mtime == old && cycles < 4 * TICK_PERIOD) begin
            @(negedge clock);
            cycles++;
        end
        if (clint_mtime == old) begin
            check("mtime_stuck", clint_mtime, old + 64'd1);
        end
    endtask

    //--------------------------------------------------------------------------
    // Stimulus
    //--------------------------------------------------------------------------
    initial begin : driver
        int          c;
        int          guard;
        logic        prev_mtip;
        logic [31:0] offs[6];
        logic [31:0] off;
        int          r;

        offs = '{OFF_MSIP, OFF_CMP_LO, OFF_CMP_HI, OFF_TIME_LO, OFF_TIME_HI, 32'h0008};

        // Reset, then 100 idle clocks: ten ticks.
        reset = 1'b1;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        idle(100);
        check("mtime_after_100", clint_mtime, 64'd10);
        check("mtip_after_100", {63'd0, clint_mtip}, 64'd0);
        bus_req(OFF_TIME_LO, 32'd0, 4'b0000);

        // Increment period.
        wait_mtime_change(c);
        wait_mtime_change(c);
        check("tick_period", 64'(c), 64'(TICK_PERIOD));

        // Timer interrupt at mtime == 20.
        bus_req(OFF_CMP_LO, 32'd20, 4'b1111);
        bus_req(OFF_CMP_HI, 32'd0, 4'b1111);
        guard     = 0;
        prev_mtip = clint_mtip;
        while (clint_mtime != 64'd20 && guard < 200) begin
            prev_mtip = clint_mtip;
            @(negedge clock);
            guard++;
        end
        check("mtime_reaches_20", clint_mtime, 64'd20);
        check("mtip_rises_at_20", {63'd0, clint_mtip}, 64'd1);
        check("mtip_low_before_20", {63'd0, prev_mtip}, 64'd0);
        bus_req(OFF_CMP_HI, 32'd1, 4'b1111);
        check("mtip_drops_after_cmp_hi", {63'd0, clint_mtip}, 64'd0);

        // Software interrupt bit.
        bus_req(OFF_MSIP, 32'd1, 4'b0001);
        check("msip_set", {63'd0, clint_msip}, 64'd1);
        bus_req(OFF_MSIP, 32'd0, 4'b0000);
        check("msip_kept_on_read", {63'd0, clint_msip}, 64'd1);
        bus_req(OFF_MSIP, 32'd0, 4'b0001);
        check("msip_cleared", {63'd0, clint_msip}, 64'd0);

        // Carry across the halves.
        align_phase(0);
        bus_req(OFF_TIME_HI, 32'h0000_0000, 4'b1111);
        bus_req(OFF_TIME_LO, 32'hFFFF_FFFF, 4'b1111);
        wait_mtime_change(c);
        check("mtime_carry", clint_mtime, 64'h1_0000_0000);

        // Full wrap; mtip follows the compare (mtimecmp = 0x1_0000_0014).
        align_phase(0);
        bus_req(OFF_TIME_LO, 32'hFFFF_FFFF, 4'b1111);
        bus_req(OFF_TIME_HI, 32'hFFFF_FFFF, 4'b1111);
        check("mtip_all_ones", {63'd0, clint_mtip}, 64'd1);
        wait_mtime_change(c);
        check("mtime_wrap", clint_mtime, 64'd0);
        check("mtip_after_wrap", {63'd0, clint_mtip}, 64'd0);

        // Write landing on a tick: written bytes win, no increment.
        align_phase(TICK_PERIOD - 1);
        bus_req(OFF_TIME_LO, 32'h0000_1234, 4'b1111);
        check("mtime_lo_on_tick", {32'd0, clint_mtime[31:0]}, 64'h1234);

        // Byte write into mtimecmp lo (20 -> 0xAB14), then back-to-back reads.
        bus_req(OFF_CMP_LO, 32'h0000_AB00, 4'b0010);
        bus_req(OFF_CMP_LO, 32'd0, 4'b0000);
        bus_req(OFF_CMP_HI, 32'd0, 4'b0000);

        // Unmapped offset.
        bus_req(32'h0008, 32'd0, 4'b0000);

        // Reset together with a read: the response is dropped.
        reset       = 1'b1;
        clint_valid = 1'b1;
        clint_addr  = BASE + OFF_TIME_LO;
        clint_wstrb = 4'b0000;
        @(negedge clock);
        reset       = 1'b0;
        clint_valid = 1'b0;
        check("no_ready_after_reset", {63'd0, clint_ready}, 64'd0);
        check("mtime_after_reset", clint_mtime, 64'd0);

        // Randomized traffic.
        for (int i = 0; i < 1500; i++) begin
            r = $urandom_range(0, 99);
            if (r < 2) begin
                reset       = 1'b1;
                clint_valid = $urandom_range(0, 1) == 1;
                clint_addr  = BASE + offs[$urandom_range(0, 4)];
                clint_wdata = $urandom;
                clint_wstrb = 4'($urandom_range(0, 15));
                @(negedge clock);
                reset       = 1'b0;
                clint_valid = 1'b0;
                clint_wstrb = 4'd0;
            end else if (r < 30) begin
                idle($urandom_range(1, 3));
            end else begin
                if ($urandom_range(0, 9) == 0) begin
                    off = {16'd0, 14'($urandom_range(0, 16'h3FFF)), 2'b00};
                end else begin
                    off = offs[$urandom_range(0, 5)];
                end
                off = off | 32'($urandom_range(0, 3));
                bus_req(off, $urandom,
                        ($urandom_range(0, 9) < 3) ? 4'b0000 : 4'($urandom_range(1, 15)));
            end
        end
        idle(3);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    // Global time limit.
    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish, %0d checks, %0d errors", n_checks, n_errors);
        $fatal(1, "timeout");
    end

endmodule
